// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite constants, FSM encodings and address decode helper
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_S0_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_S1_BASE = 32'h4000_0000;
  localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_F000;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    WR_ERR_DATA,
    WR_ERR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA,
    RD_ERR
  } rd_state_e;

  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decoder.sv
// rtl/axi_lite_addr_decoder.sv - 1-master/2-slave AXI4-Lite router with internal DECERR responder
module axi_lite_addr_decoder
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] S0_BASE = DEF_S0_BASE,
  parameter logic [31:0] S0_MASK = DEF_S0_MASK,
  parameter logic [31:0] S1_BASE = DEF_S1_BASE,
  parameter logic [31:0] S1_MASK = DEF_S1_MASK
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,

  output logic [31:0] m0_axi_awaddr,
  output logic        m0_axi_awvalid,
  input  logic        m0_axi_awready,
  output logic [31:0] m0_axi_wdata,
  output logic [3:0]  m0_axi_wstrb,
  output logic        m0_axi_wvalid,
  input  logic        m0_axi_wready,
  input  logic [1:0]  m0_axi_bresp,
  input  logic        m0_axi_bvalid,
  output logic        m0_axi_bready,
  output logic [31:0] m0_axi_araddr,
  output logic        m0_axi_arvalid,
  input  logic        m0_axi_arready,
  input  logic [31:0] m0_axi_rdata,
  input  logic [1:0]  m0_axi_rresp,
  input  logic        m0_axi_rvalid,
  output logic        m0_axi_rready,

  output logic [31:0] m1_axi_awaddr,
  output logic        m1_axi_awvalid,
  input  logic        m1_axi_awready,
  output logic [31:0] m1_axi_wdata,
  output logic [3:0]  m1_axi_wstrb,
  output logic        m1_axi_wvalid,
  input  logic        m1_axi_wready,
  input  logic [1:0]  m1_axi_bresp,
  input  logic        m1_axi_bvalid,
  output logic        m1_axi_bready,
  output logic [31:0] m1_axi_araddr,
  output logic        m1_axi_arvalid,
  input  logic        m1_axi_arready,
  input  logic [31:0] m1_axi_rdata,
  input  logic [1:0]  m1_axi_rresp,
  input  logic        m1_axi_rvalid,
  output logic        m1_axi_rready
);

  wr_state_e   wr_state_q, wr_state_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic        wr_sel_q, wr_sel_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        rd_sel_q, rd_sel_d;

  logic [1:0]       m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [1:0]       m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0][1:0]  m_bresp, m_rresp;
  logic [1:0][31:0] m_rdata;

  logic wr_hit0, wr_hit1, rd_hit0, rd_hit1;

  assign m_awready = {m1_axi_awready, m0_axi_awready};
  assign m_wready  = {m1_axi_wready,  m0_axi_wready};
  assign m_bvalid  = {m1_axi_bvalid,  m0_axi_bvalid};
  assign m_bresp   = {m1_axi_bresp,   m0_axi_bresp};
  assign m_arready = {m1_axi_arready, m0_axi_arready};
  assign m_rvalid  = {m1_axi_rvalid,  m0_axi_rvalid};
  assign m_rresp   = {m1_axi_rresp,   m0_axi_rresp};
  assign m_rdata   = {m1_axi_rdata,   m0_axi_rdata};

  // S0 wins when both windows match, so sel is simply "not S0"
  assign wr_hit0 = addr_match(s_axi_awaddr, S0_BASE, S0_MASK);
  assign wr_hit1 = addr_match(s_axi_awaddr, S1_BASE, S1_MASK);
  assign rd_hit0 = addr_match(s_axi_araddr, S0_BASE, S0_MASK);
  assign rd_hit1 = addr_match(s_axi_araddr, S1_BASE, S1_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      wr_addr_q  <= '0;
      wr_sel_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
      rd_sel_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_sel_q   <= wr_sel_d;
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  // Handshake outputs are gated by reset so a mid-transaction reset silences the bus immediately
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_addr_d     = wr_addr_q;
    wr_sel_d      = wr_sel_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    m_awvalid     = '0;
    m_wvalid      = '0;
    m_bready      = '0;
    if (!reset) begin
      case (wr_state_q)
        WR_IDLE: begin
          s_axi_awready = 1'b1;
          if (s_axi_awvalid) begin
            wr_addr_d  = s_axi_awaddr;
            wr_sel_d   = !wr_hit0;
            wr_state_d = (wr_hit0 || wr_hit1) ? WR_ADDR : WR_ERR_DATA;
          end
        end
        WR_ADDR: begin
          m_awvalid[wr_sel_q] = 1'b1;
          if (m_awready[wr_sel_q]) wr_state_d = WR_DATA;
        end
        WR_DATA: begin
          m_wvalid[wr_sel_q] = s_axi_wvalid;
          s_axi_wready       = m_wready[wr_sel_q];
          if (s_axi_wvalid && m_wready[wr_sel_q]) wr_state_d = WR_RESP;
        end
        WR_RESP: begin
          s_axi_bvalid       = m_bvalid[wr_sel_q];
          s_axi_bresp        = m_bresp[wr_sel_q];
          m_bready[wr_sel_q] = s_axi_bready;
          if (m_bvalid[wr_sel_q] && s_axi_bready) wr_state_d = WR_IDLE;
        end
        WR_ERR_DATA: begin
          s_axi_wready = 1'b1;
          if (s_axi_wvalid) wr_state_d = WR_ERR_RESP;
        end
        WR_ERR_RESP: begin
          s_axi_bvalid = 1'b1;
          s_axi_bresp  = RESP_DECERR;
          if (s_axi_bready) wr_state_d = WR_IDLE;
        end
        default: wr_state_d = WR_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_addr_d     = rd_addr_q;
    rd_sel_d      = rd_sel_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rdata   = '0;
    s_axi_rresp   = RESP_OKAY;
    m_arvalid     = '0;
    m_rready      = '0;
    if (!reset) begin
      case (rd_state_q)
        RD_IDLE: begin
          s_axi_arready = 1'b1;
          if (s_axi_arvalid) begin
            rd_addr_d  = s_axi_araddr;
            rd_sel_d   = !rd_hit0;
            rd_state_d = (rd_hit0 || rd_hit1) ? RD_ADDR : RD_ERR;
          end
        end
        RD_ADDR: begin
          m_arvalid[rd_sel_q] = 1'b1;
          if (m_arready[rd_sel_q]) rd_state_d = RD_DATA;
        end
        RD_DATA: begin
          s_axi_rvalid       = m_rvalid[rd_sel_q];
          s_axi_rdata        = m_rdata[rd_sel_q];
          s_axi_rresp        = m_rresp[rd_sel_q];
          m_rready[rd_sel_q] = s_axi_rready;
          if (m_rvalid[rd_sel_q] && s_axi_rready) rd_state_d = RD_IDLE;
        end
        RD_ERR: begin
          s_axi_rvalid = 1'b1;
          s_axi_rresp  = RESP_DECERR;
          if (s_axi_rready) rd_state_d = RD_IDLE;
        end
        default: rd_state_d = RD_IDLE;
      endcase
    end
  end

  assign m0_axi_awaddr  = wr_addr_q;
  assign m1_axi_awaddr  = wr_addr_q;
  assign m0_axi_awvalid = m_awvalid[0];
  assign m1_axi_awvalid = m_awvalid[1];
  assign m0_axi_wdata   = s_axi_wdata;
  assign m1_axi_wdata   = s_axi_wdata;
  assign m0_axi_wstrb   = s_axi_wstrb;
  assign m1_axi_wstrb   = s_axi_wstrb;
  assign m0_axi_wvalid  = m_wvalid[0];
  assign m1_axi_wvalid  = m_wvalid[1];
  assign m0_axi_bready  = m_bready[0];
  assign m1_axi_bready  = m_bready[1];
  assign m0_axi_araddr  = rd_addr_q;
  assign m1_axi_araddr  = rd_addr_q;
  assign m0_axi_arvalid = m_arvalid[0];
  assign m1_axi_arvalid = m_arvalid[1];
  assign m0_axi_rready  = m_rready[0];
  assign m1_axi_rready  = m_rready[1];

endmodule

// File: tb/tb_axi_lite_addr_decoder.sv
// tb/tb_axi_lite_addr_decoder.sv - directed self-checking bench for axi_lite_addr_decoder
module tb_axi_lite_addr_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;

  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [1:0]  m0_bresp, m0_rresp;

  logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [1:0]  m1_bresp, m1_rresp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_lite_addr_decoder dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_awaddr), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .s_axi_araddr(s_araddr), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m0_axi_awaddr(m0_awaddr), .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready),
    .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb), .m0_axi_wvalid(m0_wvalid), .m0_axi_wready(m0_wready),
    .m0_axi_bresp(m0_bresp), .m0_axi_bvalid(m0_bvalid), .m0_axi_bready(m0_bready),
    .m0_axi_araddr(m0_araddr), .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(m0_arready),
    .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp), .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready),
    .m1_axi_awaddr(m1_awaddr), .m1_axi_awvalid(m1_awvalid), .m1_axi_awready(m1_awready),
    .m1_axi_wdata(m1_wdata), .m1_axi_wstrb(m1_wstrb), .m1_axi_wvalid(m1_wvalid), .m1_axi_wready(m1_wready),
    .m1_axi_bresp(m1_bresp), .m1_axi_bvalid(m1_bvalid), .m1_axi_bready(m1_bready),
    .m1_axi_araddr(m1_araddr), .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(m1_arready),
    .m1_axi_rdata(m1_rdata), .m1_axi_rresp(m1_rresp), .m1_axi_rvalid(m1_rvalid), .m1_axi_rready(m1_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 2 units later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0;
    m0_awready = 0; m0_wready = 0; m0_bresp = '0; m0_bvalid = 0;
    m0_arready = 0; m0_rdata = '0; m0_rresp = '0; m0_rvalid = 0;
    m1_awready = 0; m1_wready = 0; m1_bresp = '0; m1_bvalid = 0;
    m1_arready = 0; m1_rdata = '0; m1_rresp = '0; m1_rvalid = 0;

    cyc(); cyc(); settle();
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_arready", 32'(s_arready), 32'd0);
    cyc(); reset = 1'b0; settle();
    chk("post_rst_awready", 32'(s_awready), 32'd1);
    chk("post_rst_arready", 32'(s_arready), 32'd1);

    // mapped write to RAM, W offered early
    s_awaddr = 32'h0000_0010; s_awvalid = 1;
    s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1;
    settle();
    chk("w1_early_wready", 32'(s_wready), 32'd0);
    chk("w1_early_m0_wvalid", 32'(m0_wvalid), 32'd0);
    cyc(); s_awvalid = 0; settle();
    chk("w1_m0_awvalid", 32'(m0_awvalid), 32'd1);
    chk("w1_m0_awaddr", m0_awaddr, 32'h0000_0010);
    chk("w1_m1_awvalid", 32'(m1_awvalid), 32'd0);
    chk("w1_awready_busy", 32'(s_awready), 32'd0);
    m0_awready = 1;
    cyc(); m0_awready = 0; m0_wready = 1; settle();
    chk("w1_m0_wvalid", 32'(m0_wvalid), 32'd1);
    chk("w1_m0_wdata", m0_wdata, 32'hDEAD_BEEF);
    chk("w1_m0_wstrb", 32'(m0_wstrb), 32'hF);
    chk("w1_s_wready", 32'(s_wready), 32'd1);
    chk("w1_m1_wvalid", 32'(m1_wvalid), 32'd0);
    cyc(); s_wvalid = 0; m0_wready = 0; m0_bvalid = 1; m0_bresp = 2'b00; s_bready = 1; settle();
    chk("w1_s_bvalid", 32'(s_bvalid), 32'd1);
    chk("w1_s_bresp", 32'(s_bresp), 32'd0);
    chk("w1_m0_bready", 32'(m0_bready), 32'd1);
    chk("w1_m1_bready", 32'(m1_bready), 32'd0);
    cyc(); m0_bvalid = 0; s_bready = 0; settle();
    chk("w1_done_awready", 32'(s_awready), 32'd1);
    chk("w1_done_bvalid", 32'(s_bvalid), 32'd0);

    // mapped read from GPIO
    s_araddr = 32'h4000_0004; s_arvalid = 1; settle();
    chk("r1_arready", 32'(s_arready), 32'd1);
    cyc(); s_arvalid = 0; settle();
    chk("r1_m1_arvalid", 32'(m1_arvalid), 32'd1);
    chk("r1_m1_araddr", m1_araddr, 32'h4000_0004);
    chk("r1_m0_arvalid", 32'(m0_arvalid), 32'd0);
    m1_arready = 1;
    cyc(); m1_arready = 0; m1_rvalid = 1; m1_rdata = 32'h0000_00A5; m1_rresp = 2'b00; s_rready = 1;
    m0_rdata = 32'h1111_1111; settle();
    chk("r1_s_rvalid", 32'(s_rvalid), 32'd1);
    chk("r1_s_rdata", s_rdata, 32'h0000_00A5);
    chk("r1_s_rresp", 32'(s_rresp), 32'd0);
    chk("r1_m1_rready", 32'(m1_rready), 32'd1);
    chk("r1_m0_rready", 32'(m0_rready), 32'd0);
    cyc(); m1_rvalid = 0; s_rready = 0; settle();
    chk("r1_done_arready", 32'(s_arready), 32'd1);

    // unmapped write
    s_awaddr = 32'h8000_0000; s_awvalid = 1;
    cyc(); s_awvalid = 0; settle();
    chk("we_wready", 32'(s_wready), 32'd1);
    chk("we_m0_awvalid", 32'(m0_awvalid), 32'd0);
    chk("we_m1_awvalid", 32'(m1_awvalid), 32'd0);
    s_wvalid = 1; s_wdata = 32'h0BAD_0BAD;
    cyc(); s_wvalid = 0; settle();
    chk("we_m0_wvalid", 32'(m0_wvalid), 32'd0);
    chk("we_bvalid", 32'(s_bvalid), 32'd1);
    chk("we_bresp", 32'(s_bresp), 32'h3);
    cyc(); settle();
    chk("we_bvalid_held", 32'(s_bvalid), 32'd1);
    chk("we_bresp_held", 32'(s_bresp), 32'h3);
    s_bready = 1;
    cyc(); s_bready = 0; settle();
    chk("we_done_bvalid", 32'(s_bvalid), 32'd0);
    chk("we_done_awready", 32'(s_awready), 32'd1);

    // unmapped reads: far away, and just past the RAM window
    s_araddr = 32'h2000_0000; s_arvalid = 1;
    cyc(); s_arvalid = 0; settle();
    chk("re_rvalid", 32'(s_rvalid), 32'd1);
    chk("re_rdata", s_rdata, 32'h0);
    chk("re_rresp", 32'(s_rresp), 32'h3);
    chk("re_m0_arvalid", 32'(m0_arvalid), 32'd0);
    chk("re_m1_arvalid", 32'(m1_arvalid), 32'd0);
    s_rready = 1;
    cyc(); s_rready = 0; settle();
    chk("re_done_rvalid", 32'(s_rvalid), 32'd0);
    s_araddr = 32'h0001_0000; s_arvalid = 1;
    cyc(); s_arvalid = 0; settle();
    chk("re_edge_rresp", 32'(s_rresp), 32'h3);
    chk("re_edge_m0_arvalid", 32'(m0_arvalid), 32'd0);
    s_rready = 1;
    cyc(); s_rready = 0; settle();

    // concurrent write to RAM and read from GPIO
    s_awaddr = 32'h0000_0100; s_awvalid = 1;
    s_araddr = 32'h4000_0000; s_arvalid = 1;
    cyc(); s_awvalid = 0; s_arvalid = 0; settle();
    chk("cc_m0_awvalid", 32'(m0_awvalid), 32'd1);
    chk("cc_m0_awaddr", m0_awaddr, 32'h0000_0100);
    chk("cc_m1_awvalid", 32'(m1_awvalid), 32'd0);
    chk("cc_m1_arvalid", 32'(m1_arvalid), 32'd1);
    chk("cc_m1_araddr", m1_araddr, 32'h4000_0000);
    chk("cc_m0_arvalid", 32'(m0_arvalid), 32'd0);
    m0_awready = 1; m1_arready = 1;
    cyc(); m0_awready = 0; m1_arready = 0;
    m0_wready = 1; s_wvalid = 1; s_wdata = 32'h1234_5678; s_wstrb = 4'h3;
    m1_rvalid = 1; m1_rdata = 32'h0000_005A; m1_rresp = 2'b00; s_rready = 1; settle();
    chk("cc_m0_wvalid", 32'(m0_wvalid), 32'd1);
    chk("cc_m0_wdata", m0_wdata, 32'h1234_5678);
    chk("cc_m1_wvalid", 32'(m1_wvalid), 32'd0);
    chk("cc_s_rdata", s_rdata, 32'h0000_005A);
    chk("cc_m1_rready", 32'(m1_rready), 32'd1);
    chk("cc_m0_rready", 32'(m0_rready), 32'd0);
    cyc(); s_wvalid = 0; m0_wready = 0; m1_rvalid = 0; s_rready = 0;
    m0_bvalid = 1; m0_bresp = 2'b00; s_bready = 0;

    // B back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("bp_bvalid_%0d", i), 32'(s_bvalid), 32'd1);
      chk($sformatf("bp_bresp_%0d", i), 32'(s_bresp), 32'd0);
      chk($sformatf("bp_awready_%0d", i), 32'(s_awready), 32'd0);
      chk($sformatf("bp_m0_bready_%0d", i), 32'(m0_bready), 32'd0);
      cyc();
    end
    s_bready = 1; settle();
    chk("bp_m0_bready_rise", 32'(m0_bready), 32'd1);
    cyc(); s_bready = 0; m0_bvalid = 0; settle();
    chk("bp_done_bvalid", 32'(s_bvalid), 32'd0);
    chk("bp_done_awready", 32'(s_awready), 32'd1);

    // reset while in WR_DATA
    s_awaddr = 32'h0000_0020; s_awvalid = 1;
    cyc(); s_awvalid = 0; m0_awready = 1;
    cyc(); m0_awready = 0; s_wvalid = 1; s_wdata = 32'hCAFE_F00D; m0_wready = 0; settle();
    chk("rs_m0_wvalid_before", 32'(m0_wvalid), 32'd1);
    reset = 1; settle();
    chk("rs_m0_wvalid_during", 32'(m0_wvalid), 32'd0);
    chk("rs_s_wready_during", 32'(s_wready), 32'd0);
    chk("rs_awready_during", 32'(s_awready), 32'd0);
    cyc(); reset = 0; s_wvalid = 0; settle();
    chk("rs_m0_awvalid_after", 32'(m0_awvalid), 32'd0);
    chk("rs_m0_wvalid_after", 32'(m0_wvalid), 32'd0);
    chk("rs_bvalid_after", 32'(s_bvalid), 32'd0);
    chk("rs_awready_after", 32'(s_awready), 32'd1);

    // fresh write with zero-wait slave: AW accept, AW, W, B on consecutive cycles
    m0_awready = 1; m0_wready = 1; m0_bvalid = 1; m0_bresp = 2'b00; s_bready = 1;
    s_awaddr = 32'h0000_0030; s_awvalid = 1;
    cyc(); s_awvalid = 0; settle();
    chk("fw_m0_awvalid", 32'(m0_awvalid), 32'd1);
    chk("fw_m0_awaddr", m0_awaddr, 32'h0000_0030);
    chk("fw_bvalid_early", 32'(s_bvalid), 32'd0);
    cyc(); s_wvalid = 1; s_wdata = 32'h0000_0042; s_wstrb = 4'hF; settle();
    chk("fw_m0_wvalid", 32'(m0_wvalid), 32'd1);
    chk("fw_m0_wdata", m0_wdata, 32'h0000_0042);
    cyc(); s_wvalid = 0; settle();
    chk("fw_bvalid", 32'(s_bvalid), 32'd1);
    chk("fw_bresp", 32'(s_bresp), 32'd0);
    cyc(); m0_awready = 0; m0_wready = 0; m0_bvalid = 0; s_bready = 0; settle();
    chk("fw_done_awready", 32'(s_awready), 32'd1);
    chk("fw_done_m0_awvalid", 32'(m0_awvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_addr_decoder.md
Name: axi_lite_addr_decoder

Overview:
- 1-master to 2-slave AXI4-Lite address decoder/router between the picorv32_axi master port and the SoC slaves: slave 0 = axi_ram, slave 1 = axi_gpio.
- Decodes AW/AR addresses once per transaction and routes W/B/R to the selected slave.
- Answers unmapped addresses internally with DECERR.
- Independent write and read FSMs; one outstanding transaction per direction.

Parameters:
- S0_BASE, 32'h0000_0000, RAM base address
- S0_MASK, 32'hFFFF_0000, RAM match mask (64 KB window)
- S1_BASE, 32'h4000_0000, GPIO base address
- S1_MASK, 32'hFFFF_F000, GPIO match mask (4 KB window)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_axi_awaddr/awvalid/awready  in/in/out  32/1/1  upstream write address
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  upstream write data
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  upstream write response
- s_axi_araddr/arvalid/arready  in/in/out  32/1/1  upstream read address
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  upstream read data
- mN_axi_awaddr/awvalid/awready  out/out/in  32/1/1  downstream write address, N = 0 (RAM), 1 (GPIO)
- mN_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  downstream write data, N = 0, 1
- mN_axi_bresp/bvalid/bready  in/in/out  2/1/1  downstream write response, N = 0, 1
- mN_axi_araddr/arvalid/arready  out/out/in  32/1/1  downstream read address, N = 0, 1
- mN_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  downstream read data, N = 0, 1

Behaviour:
- Address match: (addr & Sx_MASK) == Sx_BASE.
  - S0 has priority if both windows match.
  - No match means unmapped (DECERR path).
- Write FSM states: WR_IDLE, WR_ADDR, WR_DATA, WR_RESP, WR_ERR_DATA, WR_ERR_RESP.
  - WR_IDLE: s_awready=1. On s_awvalid, latch awaddr and sel, then go to WR_ADDR (mapped) or WR_ERR_DATA (unmapped).
  - WR_ADDR: mSEL_awvalid=1 with the latched address, unchanged until mSEL_awready, then WR_DATA. Slave sees awvalid exactly 1 cycle after the upstream AW handshake.
  - WR_DATA: W passed through combinationally.
    - mSEL_wvalid = s_wvalid; s_wready = mSEL_wready.
    - On handshake go to WR_RESP.
  - WR_RESP: B passed through combinationally.
    - s_bvalid/bresp come from SEL; mSEL_bready = s_bready.
    - On handshake go to WR_IDLE.
  - WR_ERR_DATA: s_wready=1, no downstream activity. On s_wvalid go to WR_ERR_RESP.
  - WR_ERR_RESP: s_bvalid=1, bresp=2'b11, held until s_bready, then WR_IDLE.
- Read FSM states: RD_IDLE, RD_ADDR, RD_DATA, RD_ERR, with the same rules as the write FSM.
  - RD_DATA: R passed through from SEL.
  - RD_ERR: s_rvalid=1, rdata=0, rresp=2'b11, held until s_rready.
- Write-path rules:
  - s_awready is 0 in every write state except WR_IDLE.
  - W presented before the AW handshake is stalled (s_wready=0) until WR_DATA / WR_ERR_DATA.
- Unselected slave: all valid and ready outputs 0; data/addr outputs may carry don't-care values.
- Write and read FSMs run concurrently and may target the same or different slaves with no arbitration.
- Reset:
  - While reset=1, every valid/ready output is 0 and both FSMs are forced to IDLE. This includes reset asserted mid-transaction.
  - In-flight transactions are abandoned; downstream slaves share the same reset.
  - s_awready/s_arready are 1 in the first cycle after reset deasserts.
- Latency, mapped write: AW accept (cycle 0), downstream AW (cycle 1 or later), W, then B. Minimum 3 cycles AW-to-B with zero-wait slaves.
- Latency, unmapped transactions: minimum 2 cycles AW-to-B; 1 cycle AR-to-R.
- Back-pressure: valid and its payload stay stable until the handshake, in every state.

Decomposition:
- Shared package axi_lite_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_DECERR=2'b11;
  - write/read state encodings;
  - default base/mask constants;
  - address-match function.
- Natural sub-module: none required. Write and read FSMs stay in the single module as two always blocks.

Test Plan:
- Write 0x0000_0010 with wdata 0xDEADBEEF, wstrb 4'hF -> m0_awaddr=0x0000_0010 one cycle after accept; m0 W carries 0xDEADBEEF; s_bresp=2'b00; all m1 valids stay 0.
- Read 0x4000_0004 with m1 returning 0x0000_00A5 -> m1_arvalid asserted; s_rdata=0x0000_00A5, rresp=2'b00; m0_arvalid stays 0.
- Write 0x8000_0000 -> no downstream valid; s_wready=1; s_bresp=2'b11. Read 0x2000_0000 -> s_rdata=0, s_rresp=2'b11.
- Same-cycle write to 0x0000_0100 and read from 0x4000_0000 -> both complete independently with correct slave selection; no cross-talk between channels.
- Hold s_bready=0 for 5 cycles after m0_bvalid -> s_bvalid held with stable bresp; s_awready=0 throughout; completes on the cycle bready rises.
- Assert reset for 1 cycle while in WR_DATA -> next cycle all mN valids are 0 and s_bvalid=0; s_awready=1 after reset deasserts; a fresh write then succeeds.
